// File: rtl/hdmi_ctrl_pkg.sv
// rtl/hdmi_ctrl_pkg.sv - shared state encoding and frame defaults for the HDMI capture path
package hdmi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VS = 3'd1,
    ST_ARMED   = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DROP    = 3'd4,
    ST_FAULT   = 3'd5
  } ctrl_state_e;

  // 800x480 pixels at 24 bit, packed into 32-bit FIFO words
  localparam int unsigned DEF_FRAME_WORDS = 288000;
  localparam int unsigned DEF_CNT_W       = 19;
  localparam int unsigned DEF_MAX_DROPS   = 3;

  // States in which the ingester is allowed to write the pixel FIFO
  function automatic logic is_ingesting(input ctrl_state_e s);
    return (s == ST_ARMED) || (s == ST_STREAM);
  endfunction

endpackage

// File: rtl/hdmi_frame_controller_if.sv
// rtl/hdmi_frame_controller_if.sv - command/status bundle between capture host and frame controller
interface hdmi_frame_controller_if #(
  parameter int unsigned CNT_W = hdmi_ctrl_pkg::DEF_CNT_W
);

  logic             start;
  logic             stop;
  logic             v_sync;
  logic             data_valid;
  logic             fifo_full;
  logic             ingest_enable;
  logic             frame_start;
  logic             frame_done;
  logic             overflow;
  logic             fault;
  logic [CNT_W-1:0] word_count;
  logic [2:0]       state;

  // Host side: issues commands and carries the video/FIFO status in
  modport master (
    output start, stop, v_sync, data_valid, fifo_full,
    input  ingest_enable, frame_start, frame_done, overflow, fault, word_count, state
  );

  // Controller side
  modport slave (
    input  start, stop, v_sync, data_valid, fifo_full,
    output ingest_enable, frame_start, frame_done, overflow, fault, word_count, state
  );

endinterface

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 1-bit registered rising-edge detector with configurable reset value
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next value of the delayed copy is simply the current input
  always_comb begin
    prev_d = d;
  end

  // One-cycle delayed copy; RESET_VAL=1 masks a level already high at reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/hdmi_frame_controller.sv
// rtl/hdmi_frame_controller.sv - arms, counts and supervises HDMI frame capture into the pixel FIFO
module hdmi_frame_controller
  import hdmi_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned MAX_DROPS   = DEF_MAX_DROPS
) (
  input  logic             i_clock,
  input  logic             i_nReset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_vSync,
  input  logic             i_dataValid,
  input  logic             i_fifoFull,
  output logic             o_ingestEnable,
  output logic             o_frameStart,
  output logic             o_frameDone,
  output logic             o_overflow,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_wordCount,
  output logic [2:0]       o_state
);

  localparam int unsigned DROP_W = (MAX_DROPS < 1) ? 1 : $clog2(MAX_DROPS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(FRAME_WORDS - 1);
  localparam logic [DROP_W-1:0] DROP_LIMIT = DROP_W'(MAX_DROPS);

  // The word counter must be able to hold a full frame
  if (CNT_W < 32 && (32'd1 << CNT_W) <= FRAME_WORDS) begin : g_bad_cnt_w
    $error("CNT_W too narrow for FRAME_WORDS");
  end

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              stop_pending_q, stop_pending_d;
  logic              overflow_q, overflow_d;
  logic              frame_done_q, frame_done_d;
  logic              ingest_en_q, ingest_en_d;
  logic              frame_start;
  logic              vs_rise;

  // Reset value 1: a vSync already high when reset releases is not a new frame
  sync_edge_detect #(
    .RESET_VAL(1'b1)
  ) u_vs_edge (
    .clk    (i_clock),
    .resetn (i_nReset),
    .d      (i_vSync),
    .rise   (vs_rise)
  );

  // Next-state, counter and status computation for the capture FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    frame_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous stop cancels the start
        if (i_start && !i_stop) begin
          state_d    = ST_WAIT_VS;
          overflow_d = 1'b0;
          drop_d     = '0;
        end
      end
      ST_WAIT_VS: begin
        if (stop_pending_q) begin
          state_d = ST_IDLE;
        end else if (vs_rise) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (stop_pending_q) begin
          state_d = ST_IDLE;
        end else if (i_dataValid) begin
          state_d     = ST_STREAM;
          frame_start = 1'b1;
          cnt_d       = CNT_W'(1);
        end
      end
      ST_STREAM: begin
        if (i_dataValid && i_fifoFull) begin
          // Word lost to a full FIFO: frame is corrupt, do not count it
          state_d    = ST_DROP;
          overflow_d = 1'b1;
          drop_d     = drop_q + 1'b1;
        end else if (i_dataValid && (cnt_q == LAST_CNT)) begin
          state_d      = stop_pending_q ? ST_IDLE : ST_ARMED;
          frame_done_d = 1'b1;
          cnt_d        = '0;
          drop_d       = '0;
        end else if (vs_rise) begin
          // New frame began before this one filled: short frame
          state_d    = ST_DROP;
          overflow_d = 1'b1;
          drop_d     = drop_q + 1'b1;
        end else if (i_dataValid) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DROP: begin
        if (drop_q == DROP_LIMIT) begin
          state_d = ST_FAULT;
        end else if (stop_pending_q) begin
          state_d = ST_IDLE;
        end else if (vs_rise) begin
          state_d = ST_ARMED;
        end
      end
      ST_FAULT: begin
        if (i_start && !i_stop) begin
          state_d    = ST_WAIT_VS;
          overflow_d = 1'b0;
          drop_d     = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // IDLE already honours a stop, so the flag only lives outside IDLE
    stop_pending_d = (state_d == ST_IDLE) ? 1'b0 : (stop_pending_q | i_stop);

    // Counter only carries a value while streaming or frozen in DROP for debug
    if (state_d != ST_STREAM && state_d != ST_DROP) begin
      cnt_d = '0;
    end

    // Derived from the next state so the enable moves only with a transition
    ingest_en_d = is_ingesting(state_d);
  end

  // State and status registers with synchronous active-low reset
  always_ff @(posedge i_clock) begin
    if (!i_nReset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      drop_q         <= '0;
      stop_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      ingest_en_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      drop_q         <= drop_d;
      stop_pending_q <= stop_pending_d;
      overflow_q     <= overflow_d;
      frame_done_q   <= frame_done_d;
      ingest_en_q    <= ingest_en_d;
    end
  end

  assign o_ingestEnable = ingest_en_q;
  assign o_frameStart   = frame_start;
  assign o_frameDone    = frame_done_q;
  assign o_overflow     = overflow_q;
  assign o_fault        = (state_q == ST_FAULT);
  assign o_wordCount    = cnt_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_hdmi_frame_controller.sv
// tb/tb_hdmi_frame_controller.sv - directed self-checking bench for hdmi_frame_controller
module tb_hdmi_frame_controller;

  localparam int unsigned FW  = 12;
  localparam int unsigned CW  = 4;
  localparam int unsigned MXD = 2;

  localparam int S_IDLE    = 0;
  localparam int S_WAIT_VS = 1;
  localparam int S_ARMED   = 2;
  localparam int S_STREAM  = 3;
  localparam int S_DROP    = 4;
  localparam int S_FAULT   = 5;

  logic clk = 1'b0;
  logic nreset;
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;

  always #5 clk = ~clk;

  hdmi_frame_controller_if #(.CNT_W(CW)) bus ();

  hdmi_frame_controller #(
    .FRAME_WORDS (FW),
    .CNT_W       (CW),
    .MAX_DROPS   (MXD)
  ) dut (
    .i_clock        (clk),
    .i_nReset       (nreset),
    .i_start        (bus.start),
    .i_stop         (bus.stop),
    .i_vSync        (bus.v_sync),
    .i_dataValid    (bus.data_valid),
    .i_fifoFull     (bus.fifo_full),
    .o_ingestEnable (bus.ingest_enable),
    .o_frameStart   (bus.frame_start),
    .o_frameDone    (bus.frame_done),
    .o_overflow     (bus.overflow),
    .o_fault        (bus.fault),
    .o_wordCount    (bus.word_count),
    .o_state        (bus.state)
  );

  // Count every frame-done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.frame_done) done_seen <= done_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    bus.v_sync = 1'b1;
    cyc();
    bus.v_sync = 1'b0;
    cyc();
  endtask

  task automatic words(input int n);
    bus.data_valid = 1'b1;
    repeat (n) cyc();
    bus.data_valid = 1'b0;
  endtask

  initial begin
    nreset         = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.v_sync     = 1'b0;
    bus.data_valid = 1'b0;
    bus.fifo_full  = 1'b0;
    cyc();
    cyc();

    check("rst_state",   32'(bus.state), S_IDLE);
    check("rst_ingest",  32'(bus.ingest_enable), 0);
    check("rst_fstart",  32'(bus.frame_start), 0);
    check("rst_fdone",   32'(bus.frame_done), 0);
    check("rst_ovf",     32'(bus.overflow), 0);
    check("rst_fault",   32'(bus.fault), 0);
    check("rst_count",   32'(bus.word_count), 0);
    nreset = 1'b1;
    cyc();

    // Nominal frame
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("nom_wait_state", 32'(bus.state), S_WAIT_VS);
    check("nom_wait_ingest", 32'(bus.ingest_enable), 0);
    vsync_pulse();
    check("nom_armed_state", 32'(bus.state), S_ARMED);
    check("nom_armed_ingest", 32'(bus.ingest_enable), 1);
    check("nom_armed_count", 32'(bus.word_count), 0);
    bus.data_valid = 1'b1;
    #1;
    check("nom_fstart", 32'(bus.frame_start), 1);
    cyc();
    check("nom_w1_state", 32'(bus.state), S_STREAM);
    check("nom_w1_count", 32'(bus.word_count), 1);
    words(10);
    check("nom_w11_count", 32'(bus.word_count), 11);
    check("nom_w11_fdone", 32'(bus.frame_done), 0);
    words(1);
    check("nom_fdone", 32'(bus.frame_done), 1);
    check("nom_end_count", 32'(bus.word_count), 0);
    check("nom_end_state", 32'(bus.state), S_ARMED);
    check("nom_end_ingest", 32'(bus.ingest_enable), 1);
    cyc();
    check("nom_fdone_pulse", 32'(bus.frame_done), 0);
    check("nom_done_seen", 32'(done_seen), 1);

    // Overflow on word 5, then recovery
    words(4);
    check("ovf_w4_count", 32'(bus.word_count), 4);
    bus.data_valid = 1'b1;
    bus.fifo_full  = 1'b1;
    cyc();
    bus.data_valid = 1'b0;
    bus.fifo_full  = 1'b0;
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_ingest", 32'(bus.ingest_enable), 0);
    check("ovf_state", 32'(bus.state), S_DROP);
    vsync_pulse();
    check("ovf_rearm_state", 32'(bus.state), S_ARMED);
    check("ovf_rearm_count", 32'(bus.word_count), 0);
    check("ovf_sticky", 32'(bus.overflow), 1);
    words(12);
    check("ovf_clean_fdone", 32'(bus.frame_done), 1);
    check("ovf_clean_state", 32'(bus.state), S_ARMED);
    cyc();
    check("ovf_done_seen", 32'(done_seen), 2);

    // Two consecutive short frames -> FAULT
    words(7);
    check("flt_w7_count", 32'(bus.word_count), 7);
    vsync_pulse();
    check("flt_drop1_state", 32'(bus.state), S_DROP);
    vsync_pulse();
    check("flt_rearm_state", 32'(bus.state), S_ARMED);
    words(7);
    bus.v_sync = 1'b1;
    cyc();
    bus.v_sync = 1'b0;
    check("flt_drop2_state", 32'(bus.state), S_DROP);
    cyc();
    check("flt_state", 32'(bus.state), S_FAULT);
    check("flt_fault", 32'(bus.fault), 1);
    check("flt_ingest", 32'(bus.ingest_enable), 0);
    check("flt_done_seen", 32'(done_seen), 2);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("flt_exit_state", 32'(bus.state), S_WAIT_VS);
    check("flt_exit_fault", 32'(bus.fault), 0);
    check("flt_exit_ovf", 32'(bus.overflow), 0);

    // Stop mid-frame finishes the frame, then IDLE
    vsync_pulse();
    check("stp_armed", 32'(bus.state), S_ARMED);
    words(5);
    bus.data_valid = 1'b1;
    bus.stop       = 1'b1;
    cyc();
    bus.stop = 1'b0;
    words(5);
    check("stp_w11_count", 32'(bus.word_count), 11);
    check("stp_w11_state", 32'(bus.state), S_STREAM);
    words(1);
    check("stp_fdone", 32'(bus.frame_done), 1);
    check("stp_idle_state", 32'(bus.state), S_IDLE);
    check("stp_idle_ingest", 32'(bus.ingest_enable), 0);
    cyc();
    check("stp_done_seen", 32'(done_seen), 3);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("stp_both_state", 32'(bus.state), S_IDLE);
    cyc();
    check("stp_both_hold", 32'(bus.state), S_IDLE);

    // Reset at word 9 with vSync held high through release
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    vsync_pulse();
    words(8);
    check("rmf_w8_count", 32'(bus.word_count), 8);
    bus.data_valid = 1'b1;
    bus.v_sync     = 1'b1;
    nreset         = 1'b0;
    cyc();
    bus.data_valid = 1'b0;
    check("rmf_state", 32'(bus.state), S_IDLE);
    check("rmf_ingest", 32'(bus.ingest_enable), 0);
    check("rmf_fdone", 32'(bus.frame_done), 0);
    check("rmf_count", 32'(bus.word_count), 0);
    check("rmf_fstart", 32'(bus.frame_start), 0);
    nreset = 1'b1;
    cyc();
    check("rmf_fdone2", 32'(bus.frame_done), 0);
    check("rmf_done_seen", 32'(done_seen), 3);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    check("rmf_no_false_arm", 32'(bus.state), S_WAIT_VS);
    bus.v_sync = 1'b0;
    cyc();
    bus.v_sync = 1'b1;
    cyc();
    bus.v_sync = 1'b0;
    check("rmf_new_rise_arm", 32'(bus.state), S_ARMED);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
